// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter that multiplexes NREQ cache request ports onto a single
//   RAM port. A grant is registered in an IDLE arbitration cycle and then held
//   (LOCK) until the owner's transaction completes or is abandoned. After each
//   completion the priority pointer moves to the port after the owner, so no
//   port can starve.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   req_ren / req_wen    per-port read / write request (NREQ bits)
//   req_addr             per-port address, port i at [i*ADDR_W +: ADDR_W]
//   req_store            per-port write data, port i at [i*WORD_W +: WORD_W]
//   req_wait             per-port wait, 0 = transaction completes this cycle
//   req_load             per-port read data (only the reading owner sees ramload)
//   ramstate             RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   ramload              RAM read data
//   ramaddr / ramstore   RAM address / write data
//   ramREN / ramWEN      RAM read / write enable
//   owner                current (or most recent) grant index, for debug
module mem_arbiter_rr #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*WORD_W-1:0]   req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [NREQ*WORD_W-1:0]   req_load,
    input  logic [1:0]               ramstate,
    input  logic [WORD_W-1:0]        ramload,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int OW = $clog2(NREQ);

    // Encoding matches the RAM model's ramstate_t (FREE, BUSY, ACCESS, ERROR).
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [OW-1:0]   owner_nxt;

    logic            grant_found;
    logic [OW-1:0]   grant_idx;

    logic            own_ren, own_wen;
    logic [ADDR_W-1:0] own_addr;
    logic [WORD_W-1:0] own_store;

    // Index increment that wraps at NREQ explicitly, so non-power-of-two
    // port counts never step into an unused encoding.
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        if (int'(v) == NREQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Select the owner's request signals.
    always_comb begin
        own_ren   = 1'b0;
        own_wen   = 1'b0;
        own_addr  = '0;
        own_store = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(owner) == i) begin
                own_ren   = req_ren[i];
                own_wen   = req_wen[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_store = req_store[i*WORD_W +: WORD_W];
            end
        end
    end

    // First pending port searching rr_ptr, rr_ptr+1, ... (mod NREQ).
    always_comb begin
        logic [OW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && (req_ren[cand] || req_wen[cand])) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        req_wait   = '1;
        req_load   = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state)
            IDLE: begin
                // Arbitration cycle only; RAM is driven from the next cycle.
                if (grant_found) begin
                    state_nxt = LOCK;
                    owner_nxt = grant_idx;
                end
            end
            LOCK: begin
                if (!(own_ren || own_wen)) begin
                    // Owner abandoned the request: release without rotating.
                    state_nxt = IDLE;
                end else begin
                    ramaddr = own_addr;
                    if (own_ren) begin
                        ramREN = 1'b1;
                    end else begin
                        ramWEN   = 1'b1;
                        ramstore = own_store;
                    end
                    // FREE, BUSY and ERROR all hold the lock.
                    if (ramstate == RAM_ACCESS) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = wrap_inc(owner);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        for (int i = 0; i < NREQ; i++) begin
            if (state == LOCK && int'(owner) == i) begin
                if (req_ren[i]) begin
                    req_load[i*WORD_W +: WORD_W] = ramload;
                end
                if ((req_ren[i] || req_wen[i]) && ramstate == RAM_ACCESS) begin
                    req_wait[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr
//   Self-checking bench for mem_arbiter_rr (NREQ=4, 32-bit address/data).
//   Directed scenarios check fixed expectations; a randomized run compares
//   every cycle against a transaction-level reference model of the arbiter.
module tb_mem_arbiter_rr;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int OW     = $clog2(NREQ);
    localparam int VW     = NREQ + 2 + ADDR_W + WORD_W + NREQ*WORD_W + OW;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam logic [VW-1:0] RESET_VEC = {{NREQ{1'b1}}, {(VW-NREQ){1'b0}}};

    logic                    CLK;
    logic                    nRST;
    logic [NREQ-1:0]         req_ren;
    logic [NREQ-1:0]         req_wen;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*WORD_W-1:0]  req_store;
    logic [NREQ-1:0]         req_wait;
    logic [NREQ*WORD_W-1:0]  req_load;
    logic [1:0]              ramstate;
    logic [WORD_W-1:0]       ramload;
    logic [ADDR_W-1:0]       ramaddr;
    logic [WORD_W-1:0]       ramstore;
    logic                    ramREN;
    logic                    ramWEN;
    logic [OW-1:0]           owner;

    int errors = 0;
    int checks = 0;

    // Reference model: is a transaction in progress, for whom, and who has
    // priority for the next grant.
    bit m_locked;
    int m_owner;
    int m_ptr;

    mem_arbiter_rr #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .req_ren  (req_ren),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_store(req_store),
        .req_wait (req_wait),
        .req_load (req_load),
        .ramstate (ramstate),
        .ramload  (ramload),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .owner    (owner)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
    endtask

    task automatic model_clock();
        if (!nRST) begin
            model_reset();
            return;
        end
        if (!m_locked) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (req_ren[idx] || req_wen[idx]) begin
                    m_locked = 1'b1;
                    m_owner  = idx;
                    break;
                end
            end
        end else if (!(req_ren[m_owner] || req_wen[m_owner])) begin
            m_locked = 1'b0;
        end else if (ramstate == ACCESS) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NREQ;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NREQ-1:0]        w;
        logic [NREQ*WORD_W-1:0] ld;
        logic                   rr;
        logic                   ww;
        logic [ADDR_W-1:0]      a;
        logic [WORD_W-1:0]      s;
        int                     o;
        w = '1; ld = '0; rr = 1'b0; ww = 1'b0; a = '0; s = '0;
        o = m_owner;
        if (nRST && m_locked) begin
            if (req_ren[o]) begin
                rr = 1'b1;
                a  = req_addr[o*ADDR_W +: ADDR_W];
                ld[o*WORD_W +: WORD_W] = ramload;
            end else if (req_wen[o]) begin
                ww = 1'b1;
                a  = req_addr[o*ADDR_W +: ADDR_W];
                s  = req_store[o*WORD_W +: WORD_W];
            end
            if ((req_ren[o] || req_wen[o]) && ramstate == ACCESS) begin
                w[o] = 1'b0;
            end
        end
        return {w, rr, ww, a, s, ld, OW'(o)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {req_wait, ramREN, ramWEN, ramaddr, ramstore, req_load, owner};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #2;
    endtask

    task automatic clear_inputs();
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_store = '0;
        ramstate  = FREE;
        ramload   = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        model_reset();
        clear_inputs();
        req_ren  = '1;
        ramstate = ACCESS;
        ramload  = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++;
            if (dut_vec() !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", c, dut_vec(), RESET_VEC);
            end
        end
        nRST = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        req_ren[2] = 1'b1;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h40;
        ramstate = BUSY;
        #1;
        checks++;
        if (ramREN !== 1'b0 || req_wait !== 4'b1111) begin
            errors++;
            $display("FAIL single_arb_cycle: ramREN=%b wait=%b want ramREN=0 wait=1111", ramREN, req_wait);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if ({ramREN, ramWEN, ramaddr, req_wait, owner} !== {1'b1, 1'b0, 32'h40, 4'b1111, 2'd2}) begin
                errors++;
                $display("FAIL single_busy cycle %0d: REN=%b WEN=%b addr=%h wait=%b owner=%0d want 1 0 00000040 1111 2",
                         c, ramREN, ramWEN, ramaddr, req_wait, owner);
            end
            tick();
        end
        ramstate = ACCESS;
        ramload  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({req_wait, req_load[2*WORD_W +: WORD_W], ramREN} !== {4'b1011, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL single_access: wait=%b load2=%h REN=%b want 1011 deadbeef 1",
                     req_wait, req_load[2*WORD_W +: WORD_W], ramREN);
        end
        tick();
        req_ren  = '0;
        ramstate = FREE;
        ramload  = '0;
        #1;
        checks++;
        if (req_wait !== 4'b1111 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL single_after: wait=%b REN=%b want 1111 0", req_wait, ramREN);
        end
        // With every port pending, the next grant reveals the rotated pointer.
        req_ren = '1;
        tick();
        #1;
        checks++;
        if (owner !== 2'd3 || ramREN !== 1'b1) begin
            errors++;
            $display("FAIL single_next_ptr: owner=%0d REN=%b want 3 1", owner, ramREN);
        end
        req_ren = '0;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        nRST = 1'b0;
        model_reset();
        clear_inputs();
        req_wen[0] = 1'b1;
        req_addr[0*ADDR_W +: ADDR_W]  = 32'h10;
        req_store[0*WORD_W +: WORD_W] = 32'h55;
        req_ren[1] = 1'b1;
        req_addr[1*ADDR_W +: ADDR_W]  = 32'h20;
        ramstate = ACCESS;
        ramload  = 32'hA5A5_A5A5;
        tick();
        nRST = 1'b1;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL simul_arb: REN=%b WEN=%b want 0 0", ramREN, ramWEN);
        end
        tick();
        #1;
        checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, req_wait, owner} !== {1'b1, 1'b0, 32'h10, 32'h55, 4'b1110, 2'd0}) begin
            errors++;
            $display("FAIL simul_port0_write: WEN=%b REN=%b addr=%h store=%h wait=%b owner=%0d want 1 0 00000010 00000055 1110 0",
                     ramWEN, ramREN, ramaddr, ramstore, req_wait, owner);
        end
        tick();
        req_wen[0] = 1'b0;
        #1;
        checks++;
        if (req_wait !== 4'b1111 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL simul_bubble: wait=%b REN=%b WEN=%b want 1111 0 0", req_wait, ramREN, ramWEN);
        end
        tick();
        #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, req_wait, req_load[1*WORD_W +: WORD_W], owner} !==
            {1'b1, 1'b0, 32'h20, 4'b1101, 32'hA5A5_A5A5, 2'd1}) begin
            errors++;
            $display("FAIL simul_port1_read: REN=%b WEN=%b addr=%h wait=%b load1=%h owner=%0d want 1 0 00000020 1101 a5a5a5a5 1",
                     ramREN, ramWEN, ramaddr, req_wait, req_load[1*WORD_W +: WORD_W], owner);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_wait;
        do_reset();
        req_ren  = '1;
        ramstate = ACCESS;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 32'h1000 + 32'(i);
        end
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_wait = (c % 2 == 1) ? ~(4'b0001 << ((c / 2) % NREQ)) : 4'b1111;
            checks++;
            if (req_wait !== exp_wait) begin
                errors++;
                $display("FAIL fair_wait cycle %0d: got %b want %b", c, req_wait, exp_wait);
            end
            if (c % 2 == 1) begin
                checks++;
                if (owner !== OW'((c / 2) % NREQ)) begin
                    errors++;
                    $display("FAIL fair_grant cycle %0d: owner=%0d want %0d", c, owner, (c / 2) % NREQ);
                end
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_ren_wen();
        do_reset();
        req_ren[3] = 1'b1;
        req_wen[3] = 1'b1;
        req_addr[3*ADDR_W +: ADDR_W]  = 32'h300;
        req_store[3*WORD_W +: WORD_W] = 32'h77;
        ramstate = ACCESS;
        ramload  = 32'h1234_5678;
        tick();
        #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore, req_wait, req_load[3*WORD_W +: WORD_W]} !==
            {1'b1, 1'b0, 32'h300, 32'h0, 4'b0111, 32'h1234_5678}) begin
            errors++;
            $display("FAIL ren_wen_read_wins: REN=%b WEN=%b addr=%h store=%h wait=%b load3=%h want 1 0 00000300 00000000 0111 12345678",
                     ramREN, ramWEN, ramaddr, ramstore, req_wait, req_load[3*WORD_W +: WORD_W]);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        req_ren[1] = 1'b1;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h111;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h222;
        ramstate = BUSY;
        tick();
        #1;
        checks++;
        if (ramREN !== 1'b1 || owner !== 2'd1) begin
            errors++;
            $display("FAIL abort_granted: REN=%b owner=%0d want 1 1", ramREN, owner);
        end
        tick();
        req_ren[1] = 1'b0;
        #1;
        checks++;
        if ({ramREN, ramWEN, req_wait} !== {1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL abort_drop: REN=%b WEN=%b wait=%b want 0 0 1111", ramREN, ramWEN, req_wait);
        end
        tick();
        req_ren[1] = 1'b1;
        req_ren[2] = 1'b1;
        #1;
        checks++;
        if (ramREN !== 1'b0 || req_wait !== 4'b1111) begin
            errors++;
            $display("FAIL abort_idle: REN=%b wait=%b want 0 1111", ramREN, req_wait);
        end
        tick();
        #1;
        checks++;
        if ({owner, ramREN, ramaddr} !== {2'd1, 1'b1, 32'h111}) begin
            errors++;
            $display("FAIL abort_regrant: owner=%0d REN=%b addr=%h want 1 1 00000111", owner, ramREN, ramaddr);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        // Complete one read on port 1 so the pointer moves away from 0.
        req_ren[1] = 1'b1;
        ramstate   = ACCESS;
        tick();
        tick();
        clear_inputs();
        tick();
        req_ren[0] = 1'b1;
        ramstate   = BUSY;
        tick();
        #1;
        checks++;
        if (ramREN !== 1'b1 || owner !== 2'd0) begin
            errors++;
            $display("FAIL midreset_locked: REN=%b owner=%0d want 1 0", ramREN, owner);
        end
        nRST = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ramREN, ramWEN, req_wait, owner} !== {1'b0, 1'b0, 4'b1111, 2'd0}) begin
            errors++;
            $display("FAIL midreset_async: REN=%b WEN=%b wait=%b owner=%0d want 0 0 1111 0",
                     ramREN, ramWEN, req_wait, owner);
        end
        tick();
        nRST     = 1'b1;
        req_ren  = '1;
        ramstate = ACCESS;
        #1;
        checks++;
        if (ramREN !== 1'b0 || req_wait !== 4'b1111) begin
            errors++;
            $display("FAIL midreset_idle: REN=%b wait=%b want 0 1111", ramREN, req_wait);
        end
        tick();
        #1;
        checks++;
        if (owner !== 2'd0 || req_wait !== 4'b1110) begin
            errors++;
            $display("FAIL midreset_ptr: owner=%0d wait=%b want 0 1110", owner, req_wait);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
                model_reset();
            end else begin
                nRST = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    req_ren[i] = 1'($urandom_range(0, 1));
                    req_wen[i] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 3) == 0) begin
                    req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
                    req_store[i*WORD_W +: WORD_W] = $urandom;
                end
            end
            ramstate = 2'($urandom_range(0, 3));
            ramload  = $urandom;
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            tick();
        end
        nRST = 1'b1;
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        nRST = 1'b0;
        model_reset();
        clear_inputs();
        #2;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_ren_wen();
        test_abort();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised round-robin memory arbiter that replaces the fixed two-port (icache/dcache) arbiter.
- Multiplexes NREQ cache request ports onto the single RAM port, for example 2 cores × I/D = 4 ports.
- Registers a grant so the owner stays locked for the whole RAM transaction.
- Rotates priority after each completion so no port can starve.

Parameters:
- NREQ, 4, number of requester ports (≥2)
- ADDR_W, 32, address width
- WORD_W, 32, data width

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_ren  in  NREQ  per-port read request
- req_wen  in  NREQ  per-port write request
- req_addr  in  NREQ*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- req_store  in  NREQ*WORD_W  per-port write data
- req_wait  out  NREQ  per-port wait; 0 means transaction completes this cycle
- req_load  out  NREQ*WORD_W  per-port read data
- ramstate  in  2  cpu_types_pkg ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramload  in  WORD_W  RAM read data
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- owner  out  $clog2(NREQ)  current/last grant index (debug)

Behaviour:
- Registered state:
  - state ∈ {IDLE, LOCK}
  - owner index
  - rr_ptr: highest-priority index for the next grant
- Reset, asynchronous on nRST low:
  - state=IDLE, owner=0, rr_ptr=0
  - all req_wait=1, req_load=0
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0
- Outputs during reset and IDLE are the same as the reset values.
- Port i is pending when req_ren[i] or req_wen[i] is high.
- IDLE:
  - If any port is pending, pick the first pending index searching rr_ptr, rr_ptr+1, … mod NREQ.
  - Next cycle: owner=that index, state=LOCK.
  - No RAM signals are driven in the arbitration cycle, so the minimum latency from request to RAM drive is 1 cycle.
- LOCK, combinational RAM drive from owner o:
  - If req_ren[o]=1: ramREN=1, ramaddr=req_addr[o]. Read wins if REN and WEN are both high.
  - Else if req_wen[o]=1: ramWEN=1, ramaddr=req_addr[o], ramstore=req_store[o].
  - req_load[o]=ramload whenever req_ren[o]=1. All other ports get req_load=0.
  - Non-owner ports keep req_wait=1.
- Completion, in LOCK with ramstate==ACCESS and owner still pending:
  - req_wait[o]=0 for exactly that cycle.
  - Next cycle: state=IDLE, rr_ptr=(o+1) mod NREQ.
- ramstate FREE, BUSY or ERROR in LOCK:
  - Hold the lock, req_wait[o]=1, keep driving RAM.
  - ERROR is not a completion; it is held until the RAM leaves ERROR.
- Abort: in LOCK, if owner drops both req_ren[o] and req_wen[o]:
  - RAM enables go low that cycle and req_wait[o] stays 1.
  - Next cycle state=IDLE; rr_ptr is unchanged.
- Owner changing address or data mid-LOCK: the new value is passed through. Caches must hold stable values; this is not checked.
- Back-to-back transactions always take one IDLE bubble cycle between completions.
- Fairness: with all NREQ ports continuously pending, grants go 0,1,…,NREQ-1,0, so each port waits at most NREQ-1 transactions.
- Reset asserted mid-LOCK: outputs return to reset values immediately, asynchronously. The in-flight transaction is dropped and no wait=0 is issued.
- NREQ that is not a power of two: pointer and owner wrap with explicit mod NREQ, never via bit overflow.

Test Plan:
- Single read: port 2 ren, addr 0x40, ramstate BUSY×3 then ACCESS with ramload 0xDEADBEEF.
  - ramREN=1 from cycle 1.
  - req_wait[2]=0 and req_load[2]=0xDEADBEEF in the ACCESS cycle only.
  - rr_ptr becomes 3.
- Simultaneous: ports 0 (write 0x10←0x55) and 1 (read 0x20) both assert at reset exit, ACCESS one cycle after each grant.
  - Port 0 completes first with ramWEN=1, ramstore=0x55.
  - After the IDLE bubble, port 1 completes.
- Fairness: all 4 ports continuously pending, ACCESS every LOCK cycle.
  - Grant order 0,1,2,3,0,1.
  - Each completion is 2 cycles apart.
- REN+WEN both high on port 3: ramREN=1, ramWEN=0, read data returned.
- Abort: port 1 granted, drops ren while ramstate=BUSY.
  - RAM enables go 0 that cycle and no wait=0 occurs.
  - Next grant goes to port 1 again if it re-requests, since rr_ptr is unchanged.
- Reset mid-LOCK: nRST low while port 0 is locked with ramstate BUSY.
  - ramREN=0 and all waits=1 immediately.
  - After release, state=IDLE and rr_ptr=0.
